// File: rtl/cms_pkg.sv
// Shared definitions for the trace-window / address-filter unit:
// FSM state encoding, control register map and slot limits.
package cms_pkg;

  // Trace window FSM states; the encoding is visible on the trace_state port
  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_TRACING  = 2'd1,
    ST_DRAINING = 2'd2,
    ST_DONE     = 2'd3
  } trace_state_t;

  // Upper limit on trigger pairs and monitored ranges
  localparam int CMS_MAX_SLOTS = 8;

  // Control register map (write-only)
  localparam int CMS_ADDR_CTRL          = 'h00;
  localparam int CMS_ADDR_REARM         = 'h01;
  localparam int CMS_ADDR_POST_COUNT    = 'h02;
  localparam int CMS_ADDR_START_BASE    = 'h10;
  localparam int CMS_ADDR_END_BASE      = 'h18;
  localparam int CMS_ADDR_TRIG_EN_BASE  = 'h20;
  localparam int CMS_ADDR_RANGE_BASE    = 'h30;
  localparam int CMS_ADDR_RANGE_EN_BASE = 'h40;

endpackage

// File: rtl/cms_range_checker.sv
// Single monitored address range: inclusive unsigned compare of pc
// against optional lower and upper bounds.
module cms_range_checker #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_hi,
  input  logic            i_lo_en,
  input  logic            i_hi_en,
  output logic            o_in_range,
  output logic            o_active
);

  // A disabled bound never excludes; a range with no bound enabled is inactive
  always_comb begin
    o_in_range = (!i_lo_en || (i_pc >= i_lo)) && (!i_hi_en || (i_pc <= i_hi));
    o_active   = i_lo_en | i_hi_en;
  end

endmodule

// File: rtl/cms_trace_filter.sv
// Trace-window and address-filter unit. Start/end trigger pairs open and
// close a trace window (with optional post-trigger drain and one-shot mode),
// monitored ranges gate which traced instructions are forwarded, and the
// surviving pc/instr pairs are emitted on a registered output stream.
module cms_trace_filter
  import cms_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int N_TRIG     = 4,
  parameter int N_RANGE    = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       pc,
  input  logic [31:0]           instr,
  input  logic                  pc_valid,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [DATA_WIDTH-1:0] ctrl_wdata,
  input  logic                  ctrl_write_enable,
  output logic                  out_valid,
  output logic [XLEN-1:0]       out_pc,
  output logic [31:0]           out_instr,
  output logic [1:0]            trace_state,
  output logic [2:0]            last_trig_idx
);

  // Configuration registers
  logic                 r_one_shot;
  logic [CNT_WIDTH-1:0] r_post_count;
  logic [XLEN-1:0]      r_start_addr [N_TRIG];
  logic [XLEN-1:0]      r_end_addr   [N_TRIG];
  logic [N_TRIG-1:0]    r_start_en;
  logic [N_TRIG-1:0]    r_end_en;
  logic [XLEN-1:0]      r_lo [N_RANGE];
  logic [XLEN-1:0]      r_hi [N_RANGE];
  logic [N_RANGE-1:0]   r_lo_en;
  logic [N_RANGE-1:0]   r_hi_en;
  logic                 r_we_d;

  // Trace state
  trace_state_t         r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2:0]           r_last_idx;

  // Output registers
  logic                 r_out_valid;
  logic [XLEN-1:0]      r_out_pc;
  logic [31:0]          r_out_instr;

  // Combinational helpers
  logic                 w_wr;
  logic                 w_rearm;
  logic                 w_sample;
  logic                 w_start_hit;
  logic                 w_end_hit;
  logic [2:0]           w_start_idx;
  logic                 w_any_start_en;
  logic [N_RANGE-1:0]   w_in_range;
  logic [N_RANGE-1:0]   w_active;
  logic                 w_range_ok;
  logic                 w_traced;
  logic                 w_emit;
  trace_state_t         w_end_state;
  logic [CNT_WIDTH-1:0] w_end_cnt;

  // In edge mode a strobe held high performs a single write on its first cycle
  assign w_wr = (CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED != 0) ?
                (ctrl_write_enable && !r_we_d) : ctrl_write_enable;
  assign w_rearm  = w_wr && (ctrl_addr == ADDR_WIDTH'(CMS_ADDR_REARM)) && ctrl_wdata[0];
  assign w_sample = pc_valid && en;

  // Previous strobe level for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we_d <= 1'b0;
    end else begin
      r_we_d <= ctrl_write_enable;
    end
  end

  // Register-port decode; slots beyond N_TRIG/N_RANGE simply never match
  always_ff @(posedge clk) begin
    if (rst) begin
      r_one_shot   <= 1'b0;
      r_post_count <= '0;
      r_start_en   <= '0;
      r_end_en     <= '0;
      r_lo_en      <= '0;
      r_hi_en      <= '0;
      for (int i = 0; i < N_TRIG; i++) begin
        r_start_addr[i] <= '0;
        r_end_addr[i]   <= '0;
      end
      for (int k = 0; k < N_RANGE; k++) begin
        r_lo[k] <= '0;
        r_hi[k] <= '0;
      end
    end else if (w_wr) begin
      if (ctrl_addr == ADDR_WIDTH'(CMS_ADDR_CTRL)) begin
        r_one_shot <= ctrl_wdata[0];
      end
      if (ctrl_addr == ADDR_WIDTH'(CMS_ADDR_POST_COUNT)) begin
        r_post_count <= CNT_WIDTH'(ctrl_wdata);
      end
      for (int i = 0; i < N_TRIG; i++) begin
        if (ctrl_addr == ADDR_WIDTH'(CMS_ADDR_START_BASE + i)) begin
          r_start_addr[i] <= XLEN'(ctrl_wdata);
        end
        if (ctrl_addr == ADDR_WIDTH'(CMS_ADDR_END_BASE + i)) begin
          r_end_addr[i] <= XLEN'(ctrl_wdata);
        end
        if (ctrl_addr == ADDR_WIDTH'(CMS_ADDR_TRIG_EN_BASE + i)) begin
          r_start_en[i] <= ctrl_wdata[0];
          r_end_en[i]   <= ctrl_wdata[1];
        end
      end
      for (int k = 0; k < N_RANGE; k++) begin
        if (ctrl_addr == ADDR_WIDTH'(CMS_ADDR_RANGE_BASE + 2 * k)) begin
          r_lo[k] <= XLEN'(ctrl_wdata);
        end
        if (ctrl_addr == ADDR_WIDTH'(CMS_ADDR_RANGE_BASE + 2 * k + 1)) begin
          r_hi[k] <= XLEN'(ctrl_wdata);
        end
        if (ctrl_addr == ADDR_WIDTH'(CMS_ADDR_RANGE_EN_BASE + k)) begin
          r_lo_en[k] <= ctrl_wdata[0];
          r_hi_en[k] <= ctrl_wdata[1];
        end
      end
    end
  end

  // Trigger matching; scanning downward leaves the lowest matching index
  always_comb begin
    w_start_hit = 1'b0;
    w_end_hit   = 1'b0;
    w_start_idx = 3'd0;
    for (int i = N_TRIG - 1; i >= 0; i--) begin
      if (w_sample && r_start_en[i] && (pc == r_start_addr[i])) begin
        w_start_hit = 1'b1;
        w_start_idx = 3'(i);
      end
      if (w_sample && r_end_en[i] && (pc == r_end_addr[i])) begin
        w_end_hit = 1'b1;
      end
    end
  end

  assign w_any_start_en = |r_start_en;

  // One comparator per monitored range
  for (genvar k = 0; k < N_RANGE; k++) begin : g_range
    cms_range_checker #(
      .XLEN (XLEN)
    ) u_range (
      .i_pc       (pc),
      .i_lo       (r_lo[k]),
      .i_hi       (r_hi[k]),
      .i_lo_en    (r_lo_en[k]),
      .i_hi_en    (r_hi_en[k]),
      .o_in_range (w_in_range[k]),
      .o_active   (w_active[k])
    );
  end

  // With no active range everything passes; otherwise any active range may admit
  assign w_range_ok = (~|w_active) || (|(w_in_range & w_active));

  // Whether the current instruction falls inside the trace window, and where
  // an end trigger sends the FSM (drain first if a post count is configured)
  always_comb begin
    w_traced    = 1'b0;
    w_end_state = r_one_shot ? ST_DONE : ST_ARMED;
    w_end_cnt   = '0;
    case (r_state)
      ST_ARMED:    w_traced = w_start_hit;
      ST_TRACING:  w_traced = 1'b1;
      ST_DRAINING: w_traced = 1'b1;
      default:     w_traced = 1'b0;
    endcase
    if (r_post_count != '0) begin
      w_end_state = ST_DRAINING;
      w_end_cnt   = r_post_count;
    end
  end

  assign w_emit = w_sample && w_traced && w_range_ok;

  // Trace window FSM; rearm beats any hit, en=0 freezes everything else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_ARMED;
      r_cnt      <= '0;
      r_last_idx <= 3'd0;
    end else if (w_rearm) begin
      r_state <= ST_ARMED;
      r_cnt   <= '0;
    end else if (en) begin
      case (r_state)
        ST_ARMED: begin
          if (!w_any_start_en) begin
            r_state <= ST_TRACING;
          end else if (w_start_hit) begin
            r_last_idx <= w_start_idx;
            if (w_end_hit) begin
              r_state <= w_end_state;
              r_cnt   <= w_end_cnt;
            end else begin
              r_state <= ST_TRACING;
            end
          end
        end
        ST_TRACING: begin
          if (w_start_hit) begin
            r_last_idx <= w_start_idx;
          end
          if (w_end_hit) begin
            r_state <= w_end_state;
            r_cnt   <= w_end_cnt;
          end
        end
        ST_DRAINING: begin
          if (w_sample) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_WIDTH'(1)) begin
              r_state <= r_one_shot ? ST_DONE : ST_ARMED;
            end
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  // Registered output stream; pc/instr hold between emitted instructions
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_instr <= '0;
    end else begin
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_out_pc    <= pc;
        r_out_instr <= instr;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_pc        = r_out_pc;
  assign out_instr     = r_out_instr;
  assign trace_state   = r_state;
  assign last_trig_idx = r_last_idx;

endmodule

// File: tb/tb_cms_trace_filter.sv
// Bench for cms_trace_filter: directed scenarios plus a randomized run, all
// compared cycle by cycle against a behavioural model of the trace rules.
module tb_cms_trace_filter;

  localparam int XLEN = 64;
  localparam int AW   = 8;
  localparam int DW   = 64;
  localparam int NT   = 4;
  localparam int NR   = 4;
  localparam int CW   = 16;
  localparam int EDGE = 1;

  localparam int ARMED    = 0;
  localparam int TRACING  = 1;
  localparam int DRAINING = 2;
  localparam int DONE     = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [XLEN-1:0] pc = '0;
  logic [31:0]     instr = '0;
  logic            pc_valid = 1'b0;
  logic            en = 1'b0;
  logic [AW-1:0]   ctrl_addr = '0;
  logic [DW-1:0]   ctrl_wdata = '0;
  logic            ctrl_write_enable = 1'b0;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [1:0]      trace_state;
  logic [2:0]      last_trig_idx;

  cms_trace_filter #(
    .XLEN (XLEN), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .N_TRIG (NT),
    .N_RANGE (NR), .CNT_WIDTH (CW), .CTRL_WRITE_ENABLE_POSEDGE_TRIGGERED (EDGE)
  ) dut (
    .clk (clk), .rst (rst), .pc (pc), .instr (instr), .pc_valid (pc_valid),
    .en (en), .ctrl_addr (ctrl_addr), .ctrl_wdata (ctrl_wdata),
    .ctrl_write_enable (ctrl_write_enable), .out_valid (out_valid),
    .out_pc (out_pc), .out_instr (out_instr), .trace_state (trace_state),
    .last_trig_idx (last_trig_idx)
  );

  // Free-running clock
  always #5 clk = ~clk;

  int passCount = 0;
  int totalChecks = 0;

  // Model configuration and trace bookkeeping
  bit          mOneShot;
  int          mPost;
  logic [63:0] mStart [8];
  logic [63:0] mEnd [8];
  bit          mStartEn [8];
  bit          mEndEn [8];
  logic [63:0] mLo [8];
  logic [63:0] mHi [8];
  bit          mLoEn [8];
  bit          mHiEn [8];
  bit          mPrevWe;
  int          mState;
  int          mCnt;
  int          mIdx;
  bit          expValid;
  logic [63:0] expPc;
  logic [31:0] expInstr;

  // Observed-stream statistics for the directed scenarios
  int          seenCount;
  logic [63:0] firstPc;
  logic [63:0] lastPc;

  function automatic logic [31:0] instrOf(input logic [63:0] p);
    logic [31:0] low;
    low = p[31:0];
    return low ^ 32'h1357_9bdf;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalChecks++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic modelReset();
    mOneShot = 0; mPost = 0; mPrevWe = 0;
    for (int i = 0; i < 8; i++) begin
      mStart[i] = '0; mEnd[i] = '0; mStartEn[i] = 0; mEndEn[i] = 0;
      mLo[i] = '0; mHi[i] = '0; mLoEn[i] = 0; mHiEn[i] = 0;
    end
    mState = ARMED; mCnt = 0; mIdx = 0;
    expValid = 0; expPc = '0; expInstr = '0;
  endtask

  // Closing a window: drain if a post count is set, else finish or re-arm
  task automatic modelCloseWindow();
    if (mPost == 0) mState = mOneShot ? DONE : ARMED;
    else begin
      mState = DRAINING;
      mCnt = mPost;
    end
  endtask

  // One clock of the reference behaviour, evaluated against pre-write config
  task automatic modelStep(input bit rstI, input bit pcV, input bit enI, input logic [63:0] pcI,
                           input logic [31:0] instrI, input bit weI, input int addrI,
                           input logic [63:0] wdataI);
    bit wr, sample, sHit, eHit, anyActive, admitted, traced, anyStartEn, rearm;
    int sIdx, k;
    if (rstI) begin
      modelReset();
      return;
    end
    wr = EDGE ? (weI && !mPrevWe) : weI;
    mPrevWe = weI;
    sample = pcV && enI;
    sHit = 0; eHit = 0; sIdx = 0; anyStartEn = 0;
    for (int i = 0; i < NT; i++) begin
      anyStartEn = anyStartEn || mStartEn[i];
      if (sample && mStartEn[i] && pcI == mStart[i] && !sHit) begin
        sHit = 1;
        sIdx = i;
      end
      if (sample && mEndEn[i] && pcI == mEnd[i]) eHit = 1;
    end
    anyActive = 0; admitted = 0;
    for (int r = 0; r < NR; r++) begin
      if (mLoEn[r] || mHiEn[r]) begin
        anyActive = 1;
        if ((!mLoEn[r] || pcI >= mLo[r]) && (!mHiEn[r] || pcI <= mHi[r])) admitted = 1;
      end
    end
    traced = (mState == TRACING) || (mState == DRAINING) || (mState == ARMED && sHit);
    expValid = sample && traced && (!anyActive || admitted);
    if (expValid) begin
      expPc = pcI;
      expInstr = instrI;
    end
    rearm = wr && addrI == 1 && wdataI[0];
    if (rearm) begin
      mState = ARMED;
      mCnt = 0;
    end else if (enI) begin
      if (mState == ARMED) begin
        if (!anyStartEn) mState = TRACING;
        else if (sHit) begin
          mIdx = sIdx;
          if (eHit) modelCloseWindow();
          else mState = TRACING;
        end
      end else if (mState == TRACING) begin
        if (sHit) mIdx = sIdx;
        if (eHit) modelCloseWindow();
      end else if (mState == DRAINING && sample) begin
        mCnt = mCnt - 1;
        if (mCnt == 0) mState = mOneShot ? DONE : ARMED;
      end
    end
    if (wr) begin
      if (addrI == 'h00) mOneShot = wdataI[0];
      if (addrI == 'h02) mPost = int'(wdataI & 64'hFFFF);
      if (addrI >= 'h10 && addrI < 'h10 + NT) mStart[addrI - 'h10] = wdataI;
      if (addrI >= 'h18 && addrI < 'h18 + NT) mEnd[addrI - 'h18] = wdataI;
      if (addrI >= 'h20 && addrI < 'h20 + NT) begin
        mStartEn[addrI - 'h20] = wdataI[0];
        mEndEn[addrI - 'h20] = wdataI[1];
      end
      if (addrI >= 'h30 && addrI < 'h30 + 2 * NR) begin
        k = (addrI - 'h30) / 2;
        if ((addrI - 'h30) % 2 == 0) mLo[k] = wdataI;
        else mHi[k] = wdataI;
      end
      if (addrI >= 'h40 && addrI < 'h40 + NR) begin
        mLoEn[addrI - 'h40] = wdataI[0];
        mHiEn[addrI - 'h40] = wdataI[1];
      end
    end
  endtask

  // Drive one cycle, advance the model, then compare just after the edge
  task automatic applyStimulus(input bit rstI, input bit pcV, input bit enI, input logic [63:0] pcI,
                               input logic [31:0] instrI, input bit weI, input int addrI,
                               input logic [63:0] wdataI);
    rst = rstI; pc_valid = pcV; en = enI; pc = pcI; instr = instrI;
    ctrl_write_enable = weI; ctrl_addr = AW'(addrI); ctrl_wdata = wdataI;
    modelStep(rstI, pcV, enI, pcI, instrI, weI, addrI, wdataI);
    @(posedge clk);
    #1;
    checkOutput("out_valid", 64'(out_valid), 64'(expValid));
    checkOutput("out_pc", out_pc, expPc);
    checkOutput("out_instr", 64'(out_instr), 64'(expInstr));
    checkOutput("trace_state", 64'(trace_state), 64'(mState));
    checkOutput("last_trig_idx", 64'(last_trig_idx), 64'(mIdx));
    if (out_valid) begin
      seenCount++;
      if (seenCount == 1) firstPc = out_pc;
      lastPc = out_pc;
    end
  endtask

  task automatic stepInstr(input bit pcV, input bit enI, input logic [63:0] p);
    applyStimulus(0, pcV, enI, p, instrOf(p), 0, 0, '0);
  endtask

  task automatic writeReg(input int addr, input logic [63:0] data, input bit enI);
    applyStimulus(0, 0, enI, '0, '0, 1, addr, data);
    applyStimulus(0, 0, enI, '0, '0, 0, 0, '0);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, '0, '0, 0, 0, '0);
    applyStimulus(1, 0, 0, '0, '0, 0, 0, '0);
    seenCount = 0; firstPc = '0; lastPc = '0;
  endtask

  task automatic runPass(input logic [63:0] lo, input logic [63:0] hi);
    seenCount = 0;
    for (logic [63:0] p = lo; p <= hi; p += 4) stepInstr(1, 1, p);
  endtask

  task automatic configTrig0Pair();
    writeReg('h10, 64'h8000_0008, 0);
    writeReg('h18, 64'h8000_0040, 0);
    writeReg('h20, 64'h3, 0);
  endtask

  initial begin
    logic [63:0] rp;
    int ra;
    logic [63:0] rd;
    modelReset();

    // Reset values
    doReset();
    checkOutput("reset_out_valid", 64'(out_valid), 64'h0);
    checkOutput("reset_out_pc", out_pc, 64'h0);
    checkOutput("reset_state", 64'(trace_state), 64'(ARMED));

    // Free-running trace with no configuration
    stepInstr(0, 1, '0);
    stepInstr(0, 1, '0);
    checkOutput("freerun_state", 64'(trace_state), 64'(TRACING));
    runPass(64'h8000_0000, 64'h8000_002C);
    checkOutput("freerun_count", 64'(seenCount), 64'd12);
    checkOutput("freerun_last", lastPc, 64'h8000_002C);

    // Start/end window, no drain
    doReset();
    configTrig0Pair();
    runPass(64'h8000_0000, 64'h8000_005C);
    checkOutput("window_count", 64'(seenCount), 64'd15);
    checkOutput("window_first", firstPc, 64'h8000_0008);
    checkOutput("window_last", lastPc, 64'h8000_0040);
    checkOutput("window_state", 64'(trace_state), 64'(ARMED));

    // One-shot with drain of 3, then rearm
    doReset();
    writeReg('h00, 64'h1, 0);
    writeReg('h02, 64'h3, 0);
    configTrig0Pair();
    runPass(64'h8000_0000, 64'h8000_005C);
    checkOutput("oneshot_count1", 64'(seenCount), 64'd18);
    checkOutput("oneshot_last1", lastPc, 64'h8000_004C);
    checkOutput("oneshot_done", 64'(trace_state), 64'(DONE));
    runPass(64'h8000_0000, 64'h8000_005C);
    checkOutput("oneshot_count2", 64'(seenCount), 64'd0);
    writeReg('h01, 64'h1, 0);
    checkOutput("rearm_state", 64'(trace_state), 64'(ARMED));
    runPass(64'h8000_0000, 64'h8000_005C);
    checkOutput("oneshot_count3", 64'(seenCount), 64'd18);

    // Range filter on a free-running trace
    doReset();
    writeReg('h32, 64'h8000_0012, 0);
    writeReg('h33, 64'h8000_0030, 0);
    writeReg('h41, 64'h3, 0);
    stepInstr(0, 1, '0);
    runPass(64'h8000_0000, 64'h8000_0040);
    checkOutput("range_count", 64'(seenCount), 64'd8);
    checkOutput("range_first", firstPc, 64'h8000_0014);
    checkOutput("range_last", lastPc, 64'h8000_0030);

    // Start and end on the same instruction in slot 2
    doReset();
    writeReg('h12, 64'h8000_0010, 0);
    writeReg('h1A, 64'h8000_0010, 0);
    writeReg('h22, 64'h3, 0);
    runPass(64'h8000_0000, 64'h8000_0020);
    checkOutput("single_count", 64'(seenCount), 64'd1);
    checkOutput("single_idx", 64'(last_trig_idx), 64'd2);
    checkOutput("single_state", 64'(trace_state), 64'(ARMED));

    // Held strobe with changing data stores only the first value (5)
    doReset();
    for (int j = 0; j < 5; j++) applyStimulus(0, 0, 0, '0, '0, 1, 'h02, 64'(5 + j));
    applyStimulus(0, 0, 0, '0, '0, 0, 0, '0);
    configTrig0Pair();
    runPass(64'h8000_0000, 64'h8000_005C);
    checkOutput("held_we_count", 64'(seenCount), 64'd20);
    checkOutput("held_we_last", lastPc, 64'h8000_0054);

    // en=0 in the middle of a drain freezes it and suppresses output
    seenCount = 0;
    for (logic [63:0] p = 64'h8000_0000; p <= 64'h8000_005C; p += 4) begin
      stepInstr(1, 1, p);
      if (p == 64'h8000_0044) begin
        for (int g = 0; g < 3; g++) begin
          stepInstr(1, 0, 64'h8000_0048);
          checkOutput("gap_state", 64'(trace_state), 64'(DRAINING));
          checkOutput("gap_valid", 64'(out_valid), 64'h0);
        end
      end
    end
    checkOutput("gap_count", 64'(seenCount), 64'd20);
    checkOutput("gap_last", lastPc, 64'h8000_0054);

    // Randomized traffic and configuration against the model
    doReset();
    for (int c = 0; c < 1500; c++) begin
      ra = int'($urandom_range(0, 99));
      rp = 64'h8000_0000 + 64'(4 * $urandom_range(0, 15));
      if (ra < 2) begin
        applyStimulus(1, 0, 0, '0, '0, 0, 0, '0);
      end else if (ra < 20) begin
        rd = ($urandom_range(0, 1) == 1) ? 64'h8000_0000 + 64'(4 * $urandom_range(0, 15))
                                        : 64'($urandom_range(0, 7));
        applyStimulus(0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, rp, $urandom,
                      1, int'($urandom_range(0, 'h4F)), rd);
      end else begin
        applyStimulus(0, $urandom_range(0, 4) != 0, $urandom_range(0, 9) != 0, rp, $urandom,
                      0, 0, '0);
      end
    end

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
